// File: rtl/mcp3202_scan_scheduler_pkg.sv
// Shared types and field layout for the MCP3202 scan scheduler.
// next_ch() returns {found, channel} for the next enabled channel above ch.
package mcp3202_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    NEXT = 2'd3
  } state_t;

  localparam int CH_BIT   = 12;
  localparam int SAMPLE_W = 12;
  localparam int TDATA_W  = 16;
  localparam int FIFO_W   = TDATA_W + 1;

  function automatic logic [1:0] next_ch(input logic [1:0] mask, input logic ch);
    logic [1:0] r_res;
    r_res = 2'b00;
    if (!ch && mask[1]) r_res = 2'b11;
    return r_res;
  endfunction

endpackage

// File: rtl/mcp3202_scan_scheduler_if.sv
// Conversion-engine request/response and AXIS output bundle of the scan scheduler.
interface mcp3202_scan_scheduler_if;

  logic                              cnv_start;
  logic                              cnv_sgl;
  logic                              cnv_odd;
  logic                              cnv_busy;
  logic                              cnv_done;
  logic [mcp3202_pkg::SAMPLE_W-1:0]  cnv_data;

  logic                              m_axis_tvalid;
  logic                              m_axis_tready;
  logic [mcp3202_pkg::TDATA_W-1:0]   m_axis_tdata;
  logic                              m_axis_tlast;

  modport master (
    output cnv_start, cnv_sgl, cnv_odd,
    input  cnv_busy, cnv_done, cnv_data,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  cnv_start, cnv_sgl, cnv_odd,
    output cnv_busy, cnv_done, cnv_data,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/mcp3202_scan_scheduler_fifo.sv
// Small synchronous FIFO whose read side is an AXIS master.
// A write while full is accepted only if a read frees the slot in the same cycle.
module axis_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  output logic             o_rd_fire,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic [WIDTH-1:0] o_tdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_tvalid  = (r_count != '0);
  assign w_rd      = o_tvalid & i_tready;
  assign w_wr      = i_wr_en & (~o_full | w_rd);
  assign o_rd_fire = w_rd;
  assign o_tdata   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mcp3202_scan_scheduler.sv
// Scan scheduler: per scan tick, requests one conversion per enabled channel
// and streams {tlast, ch, sample} through the output FIFO.
//   state | meaning
//   IDLE  | waiting for a scan tick
//   REQ   | waiting for the engine to go idle, then issue cnv_start
//   WAIT  | waiting for cnv_done or timeout
//   NEXT  | pick next channel or end the scan
module mcp3202_scan_scheduler
  import mcp3202_pkg::*;
#(
  parameter int unsigned FCLK       = 100_000_000,
  parameter int unsigned FSMPL      = 500,
  parameter logic        SGL        = 1'b1,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                ch_mask,
  input  logic                      clear_status,
  mcp3202_scan_scheduler_if.master  bus,
  output logic                      overrun,
  output logic                      missed_tick,
  output logic                      timeout_err
);

  localparam int unsigned DIV = FCLK / FSMPL;
  localparam int          TW  = $clog2(DIV);
  localparam int          WW  = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [TW-1:0]     r_tick_cnt;
  logic [WW-1:0]     r_wait_cnt;
  logic [1:0]        r_scan_mask;
  logic              r_ch;
  logic              r_last;
  logic              r_cnv_start;
  logic              r_cnv_sgl;
  logic              r_cnv_odd;
  logic              r_overrun;
  logic              r_missed_tick;
  logic              r_timeout_err;

  logic              w_tick;
  logic [1:0]        w_nxt;
  logic              w_last;
  logic              w_wr_req;
  logic [FIFO_W-1:0] w_wr_data;
  logic [FIFO_W-1:0] w_rd_data;
  logic              w_full;
  logic              w_rd_fire;
  logic              w_tvalid;
  logic              w_overrun_set;
  logic              w_missed_set;
  logic              w_timeout_set;

  assign w_tick   = enable && (r_tick_cnt == TW'(DIV - 1));
  assign w_nxt    = next_ch(r_scan_mask, r_ch);
  assign w_last   = ~w_nxt[1];
  assign w_wr_req = (r_state == WAIT) && bus.cnv_done;

  always_comb begin
    w_wr_data                    = '0;
    w_wr_data[FIFO_W-1]          = w_last;
    w_wr_data[CH_BIT]            = r_ch;
    w_wr_data[SAMPLE_W-1:0]      = bus.cnv_data;
  end

  assign w_overrun_set = w_wr_req && w_full && !w_rd_fire;
  assign w_missed_set  = w_tick && (r_state != IDLE);
  assign w_timeout_set = (r_state == WAIT) && !bus.cnv_done && (r_wait_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_scan_mask <= '0;
      r_ch        <= 1'b0;
      r_last      <= 1'b0;
      r_wait_cnt  <= '0;
      r_cnv_start <= 1'b0;
      r_cnv_sgl   <= 1'b0;
      r_cnv_odd   <= 1'b0;
    end else begin
      r_cnv_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick && (ch_mask != 2'b00)) begin
            r_scan_mask <= ch_mask;
            r_ch        <= ~ch_mask[0];
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (!bus.cnv_busy) begin
            r_cnv_start <= 1'b1;
            r_cnv_odd   <= r_ch;
            r_cnv_sgl   <= SGL;
            r_wait_cnt  <= WW'(TIMEOUT - 1);
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.cnv_done) begin
            r_last  <= w_last;
            r_state <= NEXT;
          end else if (r_wait_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        NEXT: begin
          if (r_last || !enable) begin
            r_state <= IDLE;
          end else begin
            r_ch    <= w_nxt[0];
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Set has priority over clear_status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun     <= 1'b0;
      r_missed_tick <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_overrun     <= w_overrun_set | (r_overrun & ~clear_status);
      r_missed_tick <= w_missed_set  | (r_missed_tick & ~clear_status);
      r_timeout_err <= w_timeout_set | (r_timeout_err & ~clear_status);
    end
  end

  axis_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_req),
    .i_wr_data (w_wr_data),
    .o_full    (w_full),
    .o_rd_fire (w_rd_fire),
    .o_tvalid  (w_tvalid),
    .i_tready  (bus.m_axis_tready),
    .o_tdata   (w_rd_data)
  );

  assign bus.cnv_start     = r_cnv_start;
  assign bus.cnv_sgl       = r_cnv_sgl;
  assign bus.cnv_odd       = r_cnv_odd;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tdata  = w_rd_data[TDATA_W-1:0];
  assign bus.m_axis_tlast  = w_rd_data[FIFO_W-1];

  assign overrun     = r_overrun;
  assign missed_tick = r_missed_tick;
  assign timeout_err = r_timeout_err;

endmodule
